// File: rtl/instr_cache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// The slave modport is the cache's view; master is the fetch stage plus backing memory.
interface instr_cache_if;
   logic [31:0] pc;
   logic        fetch_en;
   logic [31:0] instr;
   logic        icache_stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;

   modport slave (
      input  pc, fetch_en, mem_rdata, mem_rvalid,
      output instr, icache_stall, mem_req, mem_addr
   );

   modport master (
      output pc, fetch_en, mem_rdata, mem_rvalid,
      input  instr, icache_stall, mem_req, mem_addr
   );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with combinational hit path,
// beat-by-beat line refill, global invalidate and saturating hit/miss counters.
module instr_cache #(
   parameter int unsigned LINES          = 16,
   parameter int unsigned WORDS_PER_LINE = 4
) (
   input  logic           clk,
   input  logic           reset,
   instr_cache_if.slave   bus,
   input  logic           invalidate,
   output logic [31:0]    hit_count,
   output logic [31:0]    miss_count
);

   localparam int unsigned OFF_W   = $clog2(WORDS_PER_LINE);
   localparam int unsigned IDX_W   = $clog2(LINES);
   localparam int unsigned LSB_IDX = 2 + OFF_W;
   localparam int unsigned LSB_TAG = LSB_IDX + IDX_W;
   localparam int unsigned TAG_W   = 32 - LSB_TAG;
   localparam int unsigned LAST_BEAT = WORDS_PER_LINE - 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      UPDATE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [31:0]      data_mem [LINES][WORDS_PER_LINE];
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [LINES-1:0] valid;

   logic [OFF_W-1:0] beat;
   logic [IDX_W-1:0] line_index;
   logic [TAG_W-1:0] line_tag;

   logic [OFF_W-1:0] offset;
   logic [IDX_W-1:0] index;
   logic [TAG_W-1:0] tag;
   logic             hit;
   logic             miss;
   logic             beat_wr;

   // Byte-lane bits of the fetch address carry no information for a word cache.
   logic unused_pc_bits;
   assign unused_pc_bits = ^bus.pc[1:0];

   assign offset  = bus.pc[LSB_IDX-1:2];
   assign index   = bus.pc[LSB_TAG-1:LSB_IDX];
   assign tag     = bus.pc[31:LSB_TAG];
   assign beat_wr = (state == REFILL) && bus.mem_rvalid;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Lookup, stall and next-state decode.
   always_comb begin
      state_next       = state;
      bus.instr        = '0;
      bus.icache_stall = 1'b0;
      hit              = 1'b0;
      miss             = 1'b0;
      case (state)
         IDLE: begin
            if (bus.fetch_en) begin
               if (valid[index] && (tag_mem[index] == tag)) begin
                  hit       = 1'b1;
                  bus.instr = data_mem[index][offset];
               end else begin
                  miss             = 1'b1;
                  bus.icache_stall = 1'b1;
                  state_next       = REFILL;
               end
            end
         end
         REFILL: begin
            bus.icache_stall = 1'b1;
            if (bus.mem_rvalid && (beat == OFF_W'(LAST_BEAT))) state_next = UPDATE;
         end
         UPDATE: begin
            bus.icache_stall = 1'b1;
            state_next       = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Refill control, valid bits and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid        <= '0;
         beat         <= '0;
         line_index   <= '0;
         line_tag     <= '0;
         bus.mem_req  <= 1'b0;
         bus.mem_addr <= '0;
         hit_count    <= '0;
         miss_count   <= '0;
      end else begin
         bus.mem_req <= (state_next == REFILL);

         if (miss) begin
            bus.mem_addr <= {bus.pc[31:LSB_IDX], LSB_IDX'(0)};
            line_index   <= index;
            line_tag     <= tag;
            beat         <= '0;
         end else if (beat_wr) begin
            beat <= beat + OFF_W'(1);
         end

         // Invalidate outranks the UPDATE install; the victim line is dropped at miss time.
         if (invalidate)           valid             <= '0;
         else if (state == UPDATE) valid[line_index] <= 1'b1;
         else if (miss)            valid[index]      <= 1'b0;

         if (hit && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
         if (miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
      end
   end

   // Line storage; contents are qualified by valid so no reset is needed.
   always_ff @(posedge clk) begin
      if (!reset && beat_wr)           data_mem[line_index][beat] <= bus.mem_rdata;
      if (!reset && (state == UPDATE)) tag_mem[line_index]        <= line_tag;
   end

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: fetches push the expected word, served hits pop and compare;
// each scenario task checks stall length, refill address and counters inline.
module tb_instr_cache;

   logic        clk = 1'b0;
   logic        reset;
   logic        invalidate;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   instr_cache_if bus();

   instr_cache #(.LINES(16), .WORDS_PER_LINE(4)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .invalidate (invalidate),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q [$];
   logic [31:0] m_hit = 0;
   logic [31:0] m_miss = 0;

   // Backing memory contents: the 0x40 line holds 0xA0..0xA3, everything else is address-derived.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31:4] == 28'h4) return 32'hA0 + 32'(a[3:2]);
      return a ^ 32'hDEAD_0000;
   endfunction

   // Drive one fetch until served; acts as backing memory with 'gap' idle cycles between beats.
   // inv_mode: 0 none, 1 pulse invalidate in the UPDATE cycle, 2 pulse invalidate on the first cycle.
   task automatic run_fetch(input logic [31:0] a, input int gap, input int inv_mode,
                            output int stalls, output logic [31:0] seen_addr);
      int          beat;
      int          gapc;
      bit          served;
      bit          inv_done;
      logic [31:0] exp;
      exp_q.push_back(mem_word(a));
      beat = 0; gapc = 0; stalls = 0; served = 0; inv_done = 0; seen_addr = '0;
      for (int c = 0; c < 300 && !served; c++) begin
         @(negedge clk);
         bus.pc         = a;
         bus.fetch_en   = 1'b1;
         invalidate     = 1'b0;
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = '0;
         if (inv_mode == 2 && c == 0) invalidate = 1'b1;
         if (bus.mem_req) begin
            seen_addr = bus.mem_addr;
            if (gapc == 0) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = mem_word(bus.mem_addr + 32'(beat * 4));
               beat++;
               gapc = gap;
            end else begin
               gapc--;
            end
         end else begin
            if (inv_mode == 1 && !inv_done && beat == 4) begin
               invalidate = 1'b1;
               inv_done   = 1'b1;
            end
            beat = 0;
            gapc = 0;
         end
         #1;
         if (!bus.icache_stall) begin
            served = 1'b1;
            exp = exp_q.pop_front();
            n_cmp++;
            if (bus.instr !== exp) begin
               n_bad++;
               $display("FAIL sb_instr pc=%h: got %h, want %h", a, bus.instr, exp);
            end
         end else begin
            stalls++;
         end
      end
      if (!served) begin
         void'(exp_q.pop_front());
         n_cmp++; n_bad++;
         $display("FAIL fetch_timeout pc=%h: never served, want a hit within 300 cycles", a);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; invalidate = 1'b0;
      bus.pc = '0; bus.fetch_en = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++; if (bus.mem_req !== 1'b0)    begin n_bad++; $display("FAIL rst_mem_req: got %b, want 0", bus.mem_req); end
      n_cmp++; if (bus.mem_addr !== 32'h0)  begin n_bad++; $display("FAIL rst_mem_addr: got %h, want 0", bus.mem_addr); end
      n_cmp++; if (hit_count !== 32'h0)     begin n_bad++; $display("FAIL rst_hits: got %0d, want 0", hit_count); end
      n_cmp++; if (miss_count !== 32'h0)    begin n_bad++; $display("FAIL rst_misses: got %0d, want 0", miss_count); end
      n_cmp++; if (bus.icache_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b, want 0", bus.icache_stall); end
      n_cmp++; if (bus.instr !== 32'h0)     begin n_bad++; $display("FAIL rst_instr: got %h, want 0", bus.instr); end
   endtask

   task automatic test_cold_miss();
      int st; logic [31:0] ad;
      run_fetch(32'h40, 0, 0, st, ad);
      m_miss += 1; m_hit += 1;
      n_cmp++; if (st != 6)         begin n_bad++; $display("FAIL cold_stall: got %0d, want 6", st); end
      n_cmp++; if (ad !== 32'h40)   begin n_bad++; $display("FAIL cold_mem_addr: got %h, want 00000040", ad); end
      @(negedge clk); bus.fetch_en = 1'b0; bus.mem_rvalid = 1'b0; #1;
      n_cmp++; if (miss_count !== m_miss) begin n_bad++; $display("FAIL cold_misses: got %0d, want %0d", miss_count, m_miss); end
      n_cmp++; if (hit_count !== m_hit)   begin n_bad++; $display("FAIL cold_hits: got %0d, want %0d", hit_count, m_hit); end
      n_cmp++; if (bus.mem_req !== 1'b0)  begin n_bad++; $display("FAIL cold_req_drop: got %b, want 0", bus.mem_req); end
   endtask

   task automatic test_same_line_hits();
      int st; logic [31:0] ad;
      for (int i = 1; i < 4; i++) begin
         run_fetch(32'h40 + 32'(i * 4), 0, 0, st, ad);
         m_hit += 1;
         n_cmp++; if (st != 0) begin n_bad++; $display("FAIL same_line_stall w%0d: got %0d, want 0", i, st); end
      end
      @(negedge clk); bus.fetch_en = 1'b0; #1;
      n_cmp++; if (hit_count !== m_hit) begin n_bad++; $display("FAIL same_line_hits: got %0d, want %0d", hit_count, m_hit); end
   endtask

   task automatic test_conflict();
      int st; logic [31:0] ad;
      run_fetch(32'h140, 0, 0, st, ad);
      n_cmp++; if (st != 6)        begin n_bad++; $display("FAIL conflict_stall_a: got %0d, want 6", st); end
      n_cmp++; if (ad !== 32'h140) begin n_bad++; $display("FAIL conflict_addr_a: got %h, want 00000140", ad); end
      run_fetch(32'h40, 0, 0, st, ad);
      n_cmp++; if (st != 6)        begin n_bad++; $display("FAIL conflict_stall_b: got %0d, want 6", st); end
      n_cmp++; if (ad !== 32'h40)  begin n_bad++; $display("FAIL conflict_addr_b: got %h, want 00000040", ad); end
      m_miss += 2; m_hit += 2;
      @(negedge clk); bus.fetch_en = 1'b0; #1;
      n_cmp++; if (miss_count !== m_miss) begin n_bad++; $display("FAIL conflict_misses: got %0d, want %0d", miss_count, m_miss); end
   endtask

   task automatic test_gapped_beats();
      int st; logic [31:0] ad;
      run_fetch(32'h300, 2, 0, st, ad);
      m_miss += 1; m_hit += 1;
      n_cmp++; if (st != 12)       begin n_bad++; $display("FAIL gap_stall: got %0d, want 12", st); end
      n_cmp++; if (ad !== 32'h300) begin n_bad++; $display("FAIL gap_addr: got %h, want 00000300", ad); end
      for (int i = 1; i < 4; i++) begin
         run_fetch(32'h300 + 32'(i * 4), 0, 0, st, ad);
         m_hit += 1;
         n_cmp++; if (st != 0) begin n_bad++; $display("FAIL gap_hit_stall w%0d: got %0d, want 0", i, st); end
      end
      @(negedge clk); bus.fetch_en = 1'b0; #1;
      n_cmp++; if (hit_count !== m_hit) begin n_bad++; $display("FAIL gap_hits: got %0d, want %0d", hit_count, m_hit); end
   endtask

   task automatic test_invalidate();
      int st; logic [31:0] ad;
      @(negedge clk); bus.fetch_en = 1'b0; invalidate = 1'b1;
      @(negedge clk); invalidate = 1'b0;
      run_fetch(32'h304, 0, 0, st, ad);
      m_miss += 1; m_hit += 1;
      n_cmp++; if (st != 6)  begin n_bad++; $display("FAIL inv_idle_stall: got %0d, want 6", st); end
      run_fetch(32'h140, 0, 1, st, ad);
      m_miss += 2; m_hit += 1;
      n_cmp++; if (st != 12) begin n_bad++; $display("FAIL inv_update_stall: got %0d, want 12", st); end
      run_fetch(32'h148, 0, 2, st, ad);
      m_hit += 1;
      n_cmp++; if (st != 0)  begin n_bad++; $display("FAIL inv_hit_stall: got %0d, want 0", st); end
      run_fetch(32'h14C, 0, 0, st, ad);
      m_miss += 1; m_hit += 1;
      n_cmp++; if (st != 6)  begin n_bad++; $display("FAIL inv_after_hit_stall: got %0d, want 6", st); end
      @(negedge clk); bus.fetch_en = 1'b0; invalidate = 1'b0; #1;
      n_cmp++; if (miss_count !== m_miss) begin n_bad++; $display("FAIL inv_misses: got %0d, want %0d", miss_count, m_miss); end
      n_cmp++; if (hit_count !== m_hit)   begin n_bad++; $display("FAIL inv_hits: got %0d, want %0d", hit_count, m_hit); end
   endtask

   task automatic test_reset_mid_refill();
      int st; int beats; logic [31:0] ad;
      beats = 0;
      for (int c = 0; c < 20 && beats < 2; c++) begin
         @(negedge clk);
         bus.pc = 32'h80; bus.fetch_en = 1'b1; invalidate = 1'b0;
         bus.mem_rvalid = 1'b0;
         if (bus.mem_req) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem_word(32'h80 + 32'(beats * 4));
            beats++;
         end
      end
      n_cmp++; if (beats != 2) begin n_bad++; $display("FAIL mid_beats: got %0d, want 2", beats); end
      @(negedge clk); reset = 1'b1; bus.fetch_en = 1'b0; bus.mem_rvalid = 1'b0;
      @(negedge clk); reset = 1'b0; #1;
      m_hit = 0; m_miss = 0;
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL mid_req: got %b, want 0", bus.mem_req); end
      n_cmp++; if (hit_count !== 32'h0)  begin n_bad++; $display("FAIL mid_hits: got %0d, want 0", hit_count); end
      n_cmp++; if (miss_count !== 32'h0) begin n_bad++; $display("FAIL mid_misses: got %0d, want 0", miss_count); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_0000 + 32'(i);
      end
      @(negedge clk); bus.mem_rvalid = 1'b0; #1;
      n_cmp++; if (bus.mem_req !== 1'b0)      begin n_bad++; $display("FAIL stray_req: got %b, want 0", bus.mem_req); end
      n_cmp++; if (bus.icache_stall !== 1'b0) begin n_bad++; $display("FAIL stray_stall: got %b, want 0", bus.icache_stall); end
      run_fetch(32'h80, 0, 0, st, ad);
      m_miss += 1; m_hit += 1;
      n_cmp++; if (st != 6)       begin n_bad++; $display("FAIL mid_refetch_stall: got %0d, want 6", st); end
      n_cmp++; if (ad !== 32'h80) begin n_bad++; $display("FAIL mid_refetch_addr: got %h, want 00000080", ad); end
      run_fetch(32'h84, 0, 0, st, ad);
      m_hit += 1;
      n_cmp++; if (st != 0)       begin n_bad++; $display("FAIL mid_hit_stall: got %0d, want 0", st); end
      @(negedge clk); bus.fetch_en = 1'b0; #1;
      n_cmp++; if (miss_count !== m_miss) begin n_bad++; $display("FAIL mid_final_misses: got %0d, want %0d", miss_count, m_miss); end
      n_cmp++; if (hit_count !== m_hit)   begin n_bad++; $display("FAIL mid_final_hits: got %0d, want %0d", hit_count, m_hit); end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_same_line_hits();
      test_conflict();
      test_gapped_beats();
      test_invalidate();
      test_reset_mid_refill();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_leftover: got %0d pending, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache between the fetch stage and a word-wide backing instruction memory. Hits return the instruction combinationally in the same cycle as the PC. A miss raises a stall and runs a refill state machine that fetches one full line beat-by-beat, installs it, and then resumes lookup. The block also provides a global invalidate and hit/miss counters.

## Interface
- LINES, 16: number of cache lines; power of two, at least 2.
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  byte address of the fetch; bits [1:0] ignored.
- fetch_en  in  1  lookup requested this cycle.
- invalidate  in  1  clears all valid bits.
- instr  out  32  instruction word; combinational.
- icache_stall  out  1  fetch must hold PC and IF/ID; combinational.
- mem_req  out  1  refill request level, registered.
- mem_addr  out  32  line base address, registered; offset bits are zero.
- mem_rdata  in  32  refill beat data.
- mem_rvalid  in  1  refill beat valid.
- hit_count  out  32  saturating hit counter.
- miss_count  out  32  saturating miss counter.

## Operation
- **Address split**
  - offset = pc[1+log2(WORDS_PER_LINE):2]
  - index = next log2(LINES) bits
  - tag = the remaining upper bits (24 bits at the defaults)
- **Storage:** data array of LINES×WORDS_PER_LINE words, plus a tag array and a valid bit per line.
- **Hit:** fetch_en && valid[index] && tag match, in state IDLE.
- **FSM states:** IDLE, REFILL, UPDATE.
- **IDLE**
  - Hit: instr = data[index][offset]; icache_stall = 0; hit_count increments.
  - Miss with fetch_en = 1: icache_stall = 1 and instr = 0. Latch the line base (pc with offset and byte bits zeroed) and its index/tag. Clear the beat counter. miss_count increments. Next state is REFILL.
  - fetch_en = 0: instr = 0, icache_stall = 0, counters hold.
- **REFILL**
  - mem_req = 1 and mem_addr = latched line base, both held for the whole state.
  - Each cycle with mem_rvalid = 1: write mem_rdata to data[latched index][beat], then increment beat.
  - Beats arrive in ascending word order with arbitrary gaps. A beat may arrive in the first REFILL cycle.
  - After beat WORDS_PER_LINE-1, the next state is UPDATE.
  - Throughout REFILL, icache_stall = 1, instr = 0, and pc is ignored.
- **UPDATE**
  - Write the tag; set valid[latched index] = 1.
  - mem_req = 0; icache_stall = 1; instr = 0.
  - Next state is IDLE, which re-looks-up the current pc. If pc moved during the refill, the new pc can miss again.
- **Invalidate**
  - Clears all valid bits on the clock edge in any state. It does not change the FSM state.
  - If invalidate coincides with UPDATE, invalidate wins and the refilled line is left invalid.
  - If invalidate and a hit occur in the same cycle, the hit is still reported that cycle. Lookup uses pre-edge state.
- **mem_rvalid outside REFILL** is ignored.
- **Counters** saturate at 32'hFFFF_FFFF.
- **Reset**
  - All valid bits 0, state IDLE, beat 0.
  - Outputs: mem_req 0, mem_addr 0, hit_count 0, miss_count 0. Combinational outputs therefore read icache_stall 0 and instr 0.
  - Reset during REFILL aborts the refill. The partially written line stays invalid.
- **Data array** needs no reset.

## Timing
- Hit latency: 0 cycles, combinational from pc.
- Miss detected in cycle t:
  - icache_stall = 1 from cycle t.
  - mem_req = 1 from t+1.
  - If beats k = 0..WORDS_PER_LINE-1 arrive back-to-back from t+1, the last beat is at t+WORDS_PER_LINE and UPDATE is at t+WORDS_PER_LINE+1.
  - The hit is served at t+WORDS_PER_LINE+2, when icache_stall drops.
  - Minimum stall is WORDS_PER_LINE+2 cycles (6 at the defaults). Each cycle of rvalid gap adds one cycle.
- mem_req deasserts in the cycle after the last beat (UPDATE).

## Test plan
- **Reset, then cold miss.** After reset, fetch_en=1, pc=0x0000_0040; memory returns words 0xA0..0xA3 back-to-back starting the cycle mem_req rises.
  - mem_addr=0x40.
  - icache_stall is high for 6 cycles.
  - Then instr=0xA0 with stall low.
  - miss_count=1, hit_count=1.
- **Same-line hits.** pc=0x44, then 0x48, then 0x4C.
  - instr = 0xA1, 0xA2, 0xA3 with no stall.
  - hit_count increases by 3.
- **Conflict eviction.** pc=0x140 maps to the same index as 0x40 (LINES=16).
  - Miss; refill from mem_addr=0x140.
  - A following pc=0x40 misses again; miss_count=3.
- **Gapped beats.** rvalid has 2 idle cycles between each beat.
  - icache_stall is high for 6+6=12 cycles.
  - Correct words land in the line.
- **Invalidate.** Pulse invalidate in IDLE, then fetch pc=0x140 → miss.
  - Pulse invalidate exactly in the UPDATE cycle → the line is still invalid and the next lookup misses again.
- **Reset mid-refill.** Assert reset after 2 beats.
  - Next cycle: mem_req=0, counters=0.
  - Subsequent stray rvalid is ignored.
  - Fetch of the same pc misses and refills.
